// File: rtl/mult_div_ctrl.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// A multiply takes 32 shift-add steps and a divide takes 32 restoring
// shift-subtract steps. Both run on operand magnitudes, and a single FIX
// cycle at the end applies the sign and writes HI/LO.
module mult_div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] op_q, op_d;        // multiplicand (MUL) or divisor (DIV) magnitude
    logic [63:0] prod_q, prod_d;    // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        is_div_q, is_div_d;
    logic        dbz_flag_q, dbz_flag_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    // Operand decode and magnitudes (signed ops take the two's-complement absolute value)
    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    assign is_signed = (funct == F_MULT) || (funct == F_DIV);
    assign a_mag     = (is_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign b_mag     = (is_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;

    // Shift-add step: add the multiplicand into the top half when the multiplier LSB is set
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, prod_q[63:32]} + {1'b0, op_q};
    assign mul_next = prod_q[0] ? {mul_sum, prod_q[31:1]} : {1'b0, prod_q[63:1]};

    // Restoring divide step: shift in the next dividend bit, subtract if it fits
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    assign div_shift = prod_q[63:31];
    assign div_ge    = (div_shift >= {1'b0, op_q});
    assign div_diff  = div_shift[31:0] - op_q;
    assign div_next  = div_ge ? {div_diff, prod_q[30:0], 1'b1}
                              : {div_shift[31:0], prod_q[30:0], 1'b0};

    // Sign-corrected results
    logic [63:0] prod_neg;
    logic [31:0] quo_fix, rem_fix;
    assign prod_neg = 64'd0 - prod_q;
    assign quo_fix  = neg_lo_q ? (32'd0 - prod_q[31:0])  : prod_q[31:0];
    assign rem_fix  = neg_hi_q ? (32'd0 - prod_q[63:32]) : prod_q[63:32];

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        prod_d     = prod_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        is_div_d   = is_div_q;
        dbz_flag_d = dbz_flag_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (funct)
                        F_MULT, F_MULTU: begin
                            op_d       = a_mag;
                            prod_d     = {32'd0, b_mag};
                            neg_lo_d   = is_signed & (rs_data[31] ^ rt_data[31]);
                            neg_hi_d   = 1'b0;
                            is_div_d   = 1'b0;
                            dbz_flag_d = 1'b0;
                            cnt_d      = 5'd0;
                            state_d    = S_MUL;
                        end
                        F_DIV, F_DIVU: begin
                            is_div_d = 1'b1;
                            cnt_d    = 5'd0;
                            if (rt_data == 32'd0) begin
                                dbz_flag_d = 1'b1;
                                state_d    = S_FIX;
                            end else begin
                                op_d       = b_mag;
                                prod_d     = {32'd0, a_mag};
                                neg_lo_d   = is_signed & (rs_data[31] ^ rt_data[31]);
                                neg_hi_d   = is_signed & rs_data[31];
                                dbz_flag_d = 1'b0;
                                state_d    = S_DIV;
                            end
                        end
                        F_MTHI:  hi_d = rs_data;
                        F_MTLO:  lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                if (dbz_flag_q) begin
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : prod_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            op_q       <= 32'd0;
            prod_q     <= 64'd0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            is_div_q   <= 1'b0;
            dbz_flag_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            prod_q     <= prod_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            is_div_q   <= is_div_d;
            dbz_flag_q <= dbz_flag_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed testbench for mult_div_ctrl: hand-computed products, quotients,
// latencies and pulse behaviour.
module tb_mult_div_ctrl;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [5:0]  funct;
    logic [31:0] rs_data, rt_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mult_div_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure busy length, then check the done pulse and results
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy, input logic exp_dbz,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n = 0;
        @(negedge clk);
        start = 1'b1; funct = f; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, ".busy_cycles"}, n, exp_busy);
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
        $display("op %s a=%h b=%h busy=%0d hi=%h lo=%h", tag, a, b, n, hi, lo);
        @(negedge clk);
        check({tag, ".done_1cyc"}, {31'd0, done}, 32'd0);
        check({tag, ".dbz_1cyc"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    int dn, bn;

    initial begin
        reset = 1'b1; start = 1'b0; funct = 6'd0; rs_data = 32'd0; rt_data = 32'd0;
        repeat (2) @(negedge clk);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);

        // Reset wins over a simultaneous MTHI
        start = 1'b1; funct = F_MTHI; rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        check("rst_prio.hi", hi, 32'd0);
        $display("op rst_prio hi=%h", hi);

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg3x5", F_MULT, 32'hFFFF_FFFD, 32'd5, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_min_sq", F_MULT, 32'h8000_0000, 32'h8000_0000, 33, 1'b0, 32'h4000_0000, 32'h0);
        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 33, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_2", F_DIVU, 32'd7, 32'd2, 33, 1'b0, 32'd1, 32'd3);
        run_op("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0, 32'h0, 32'h8000_0000);

        // MTHI: immediate write, no busy, no done
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; rs_data = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        check("mthi.busy", {31'd0, busy}, 32'd0);
        check("mthi.done", {31'd0, done}, 32'd0);
        check("mthi.hi", hi, 32'h0000_1234);
        $display("op mthi hi=%h lo=%h", hi, lo);

        run_op("divu_by0", F_DIVU, 32'd5, 32'd0, 1, 1'b1, 32'h0000_1234, 32'h8000_0000);

        // Unlisted funct is ignored
        start = 1'b1; funct = 6'b111111; rs_data = 32'h5555_5555; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("bad_funct.busy", {31'd0, busy}, 32'd0);
        check("bad_funct.hi", hi, 32'h0000_1234);
        $display("op bad_funct busy=%b hi=%h", busy, hi);

        // MTLO
        start = 1'b1; funct = F_MTLO; rs_data = 32'hCAFE_0001;
        @(negedge clk);
        start = 1'b0;
        check("mtlo.lo", lo, 32'hCAFE_0001);
        check("mtlo.busy", {31'd0, busy}, 32'd0);
        $display("op mtlo lo=%h", lo);

        // Reset at cycle 10 of a multiply
        start = 1'b1; funct = F_MULTU; rs_data = 32'd3; rt_data = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("rst_mid.busy_before", {31'd0, busy}, 32'd1);
        check("rst_mid.hi_hold", hi, 32'h0000_1234);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid.busy", {31'd0, busy}, 32'd0);
        check("rst_mid.hi", hi, 32'd0);
        check("rst_mid.lo", lo, 32'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        check("rst_mid.no_done", dn, 0);
        $display("op rst_mid busy=%b hi=%h lo=%h dones=%0d", busy, hi, lo, dn);
        run_op("multu_3x4", F_MULTU, 32'd3, 32'd4, 33, 1'b0, 32'd0, 32'd12);

        // DIVU 100/7 with an ignored MULT start and operand churn mid-run
        start = 1'b1; funct = F_DIVU; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        dn = 0; bn = 1;
        repeat (4) begin
            @(negedge clk);
            if (busy === 1'b1) bn++;
        end
        start = 1'b1; funct = F_MULT; rs_data = 32'd5; rt_data = 32'd9;
        check("ign.hi_hold", hi, 32'd0);
        check("ign.lo_hold", lo, 32'd12);
        @(negedge clk);
        if (busy === 1'b1) bn++;
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bn++;
            if (done === 1'b1) dn++;
        end
        check("ign.busy_cycles", bn, 33);
        check("ign.done_count", dn, 1);
        check("ign.hi", hi, 32'd2);
        check("ign.lo", lo, 32'd14);
        $display("op divu_100_7_ign busy=%0d dones=%0d hi=%h lo=%h", bn, dn, hi, lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request from the EX stage.
- funct  in  6  instruction[5:0]: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
- rs_data  in  32  operand A (dividend/multiplicand; MTHI/MTLO source).
- rt_data  in  32  operand B (divisor/multiplier).
- busy  out  1  operation in progress; the pipeline stalls on it.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  one-cycle pulse for a DIV/DIVU with rt_data==0.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.
REQ-003 The block SHALL have no parameters; width is fixed at 32.

Function
REQ-004 States SHALL be IDLE, MUL, DIV and FIX; busy SHALL be 1 exactly when state!=IDLE.
REQ-005 In IDLE, start=1 with MULT/MULTU at edge E0 SHALL latch operand magnitudes (signed ops: two's-complement absolute value; unsigned ops: raw value), latch the result sign (A[31]^B[31] for signed ops, 0 otherwise), clear the iteration counter and enter MUL.
REQ-006 MUL SHALL perform one shift-add step per cycle for exactly 32 cycles (E1..E32) into a 64-bit internal product, then enter FIX.
REQ-007 In IDLE, start=1 with DIV/DIVU and rt_data!=0 SHALL latch magnitudes and signs (quotient sign A^B, remainder sign A) and enter DIV.
REQ-008 DIV SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles (E1..E32), then enter FIX.
REQ-009 FIX SHALL last one cycle (E33), SHALL apply sign correction, and SHALL write the results to hi/lo at E33:
- MUL: {hi,lo} = the 64-bit signed or unsigned product.
- DIV: lo = quotient, hi = remainder.
After E33 the block SHALL return to IDLE and pulse done=1 for the following cycle.
REQ-010 Latency SHALL be: busy high for 33 cycles after E0; done high in cycle 34 after E0, concurrent with busy=0.
REQ-011 DIV/DIVU with rt_data==0 at E0 SHALL enter FIX with no iteration and SHALL NOT modify hi/lo; after E1, done=1 and div_by_zero=1 for one cycle; busy SHALL be high for exactly one cycle.
REQ-012 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000 (wrap, no exception).
REQ-013 MTHI/MTLO with start=1 in IDLE SHALL write rs_data to hi/lo at E0, SHALL NOT assert busy or done, and SHALL NOT change state.
REQ-014 start while busy=1 SHALL be ignored, and the in-flight operation SHALL continue unaffected.
REQ-015 start with any funct not listed in REQ-002 SHALL be ignored.
REQ-016 hi/lo SHALL hold their previous values during MUL/DIV and SHALL change only at FIX or on MTHI/MTLO.
REQ-017 Operands SHALL be sampled only at E0; changes to rs_data/rt_data during busy SHALL have no effect.
REQ-018 done and div_by_zero SHALL be registered outputs, never high for more than one consecutive cycle.

Reset
REQ-019 reset=1 at any edge SHALL force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and clear the counter and internal registers, including when reset occurs mid-operation.
REQ-020 reset SHALL take priority over start in the same cycle.
REQ-021 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-022 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles, done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
REQ-023 MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-024 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-025 MTHI 0x1234 then DIVU 5 / 0 -> one busy cycle, then done=1 and div_by_zero=1 for one cycle; hi=0x1234 and lo unchanged.
REQ-026 MULTU 3 x 4 with reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a fresh MULTU 3 x 4 -> lo=12, hi=0.
REQ-027 DIVU 100 / 7 with a MULT start at cycle 5 and operands changed mid-run -> second start ignored, lo=14, hi=2, exactly one done pulse.
